// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory stage: funct3 access codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dmem_pkg;

  // Load/store size and sign codes taken from instr[14:12]
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Core <-> data-memory request/response bundle.
// Latency: n/a (wiring only).
// Backpressure: the memory raises stall; the core holds its request while it is high.
interface dmem_if;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        stall;
  logic        misaligned;

  modport master (
    output memread, memwrite, funct3, addr, writeData,
    input  readData, stall, misaligned
  );

  modport slave (
    input  memread, memwrite, funct3, addr, writeData,
    output readData, stall, misaligned
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables.
// Latency: write on the clock edge, read is combinational.
// Backpressure: none; always accepts a write.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-granular write; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: sized/signed loads and byte-enabled stores behind a wait-state FSM.
// Latency: WAIT_STATES+2 cycles per access; commit on the edge that enters DONE.
// Backpressure: stall held (IDLE with legal request, or BUSY) until the access completes.
module dmem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic clock,
  input logic reset,
  dmem_if.slave bus
);
  import dmem_pkg::*;

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          req, bad_code, legal, commit, ram_we, load_en;
  logic [3:0]    be;
  logic [31:0]   wlane, ram_rdata, ld_val, rd_q;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign req = bus.memread | bus.memwrite;

  // Alignment and encoding legality of the current request
  always_comb begin
    bad_code = 1'b0;
    case (bus.funct3)
      F3_B, F3_BU: bad_code = 1'b0;
      F3_H, F3_HU: bad_code = bus.addr[0];
      F3_W:        bad_code = |bus.addr[1:0];
      default:     bad_code = 1'b1;
    endcase
    if (bus.memwrite && bus.funct3[2]) bad_code = 1'b1;
  end

  assign bus.misaligned = req & bad_code;
  assign legal          = req & ~bad_code;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (legal) state_nxt = (WAIT_STATES == 0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: stall and the commit strobes; reset suppresses a commit on the same edge
  always_comb begin
    bus.stall = ((state == ST_IDLE) && legal) || (state == ST_BUSY);
    commit    = (state_nxt == ST_DONE) && legal && !reset;
    ram_we    = commit && bus.memwrite;
    load_en   = commit && !bus.memwrite;
  end

  // Wait-state counter, loaded on acceptance and run down while BUSY
  always_ff @(posedge clock) begin
    if (reset)                                 cnt <= 4'd0;
    else if (state == ST_IDLE && legal)        cnt <= WS_LOAD;
    else if (state == ST_BUSY && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  // Store lane replication and byte enables
  always_comb begin
    case (bus.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << bus.addr[1:0];
        wlane = {4{bus.writeData[7:0]}};
      end
      2'b01: begin
        be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.writeData[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.writeData;
      end
    endcase
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .be    (be),
    .idx   (bus.addr[AW+1:2]),
    .wdata (wlane),
    .rdata (ram_rdata)
  );

  // Little-endian lane pick and sign/zero extension of the load result
  always_comb begin
    case (bus.addr[1:0])
      2'd0:    byte_sel = ram_rdata[7:0];
      2'd1:    byte_sel = ram_rdata[15:8];
      2'd2:    byte_sel = ram_rdata[23:16];
      default: byte_sel = ram_rdata[31:24];
    endcase
    half_sel = bus.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (bus.funct3)
      F3_B:    ld_val = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ld_val = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ld_val = {24'd0, byte_sel};
      F3_HU:   ld_val = {16'd0, half_sel};
      default: ld_val = ram_rdata;
    endcase
  end

  // Load result register, held until the next load commits
  always_ff @(posedge clock) begin
    if (reset)        rd_q <= 32'd0;
    else if (load_en) rd_q <= ld_val;
  end

  assign bus.readData = rd_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: one instance with one wait state, one with none.
// Inputs are driven at the falling edge, outputs sampled just after it.
// Every expected value below is hand-computed from the memory contents written earlier.
module tb_dmem_unit;
  import dmem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_if bus_ws1();
  dmem_if bus_ws0();

  dmem_unit #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut_ws1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_ws1)
  );

  dmem_unit #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_ws0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_ws0)
  );

  int   total = 0;
  int   bad   = 0;
  logic sel0  = 1'b0;

  logic        cur_stall, cur_mis;
  logic [31:0] cur_rd;

  always_comb begin
    if (sel0) begin
      cur_stall = bus_ws0.stall;
      cur_mis   = bus_ws0.misaligned;
      cur_rd    = bus_ws0.readData;
    end else begin
      cur_stall = bus_ws1.stall;
      cur_mis   = bus_ws1.misaligned;
      cur_rd    = bus_ws1.readData;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel0) begin
      bus_ws0.memread = rd; bus_ws0.memwrite = wr; bus_ws0.funct3 = f3;
      bus_ws0.addr = a;     bus_ws0.writeData = wd;
    end else begin
      bus_ws1.memread = rd; bus_ws1.memwrite = wr; bus_ws1.funct3 = f3;
      bus_ws1.addr = a;     bus_ws1.writeData = wd;
    end
  endtask

  // Issue one access at a falling edge, count stall cycles, release after DONE.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_stall);
    int n;
    drive(rd, wr, f3, a, wd);
    #1;
    n = 0;
    while (cur_stall && n < 40) begin
      n++;
      @(negedge clock);
      #1;
    end
    check_val({tag, "_stall"}, n, exp_stall);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_stall);
    access(tag, 1'b1, 1'b0, f3, a, 32'h0, exp_stall);
    check_val({tag, "_data"}, cur_rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sel0 = 1'b1; drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    sel0 = 1'b0; drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1;
    check_val("rst_rd",    cur_rd, 32'h0);
    check_val("rst_stall", cur_stall, 32'h0);
    check_val("rst_mis",   cur_mis, 32'h0);

    // Word store then sized loads on the one-wait-state instance
    access("sw10", 1'b0, 1'b1, F3_W, 32'h10, 32'h8000_00FF, 2);
    load("lw10",  F3_W,  32'h10, 32'h8000_00FF, 2);
    load("lb10",  F3_B,  32'h10, 32'hFFFF_FFFF, 2);
    load("lbu13", F3_BU, 32'h13, 32'h0000_0080, 2);
    load("lh12",  F3_H,  32'h12, 32'hFFFF_8000, 2);
    load("lhu10", F3_HU, 32'h10, 32'h0000_00FF, 2);

    // Byte store into lane 1 leaves the other lanes intact
    access("sb11", 1'b0, 1'b1, F3_B, 32'h11, 32'h0000_00AB, 2);
    load("lw10b", F3_W, 32'h10, 32'h8000_ABFF, 2);

    // Illegal requests: flagged, no stall, FSM stays idle, nothing changes
    drive(1'b1, 1'b0, F3_W, 32'h12, 32'h0);
    #1;
    check_val("lw12_mis",   cur_mis, 32'h1);
    check_val("lw12_stall", cur_stall, 32'h0);
    @(posedge clock); @(negedge clock); #1;
    check_val("lw12_idle",  cur_stall, 32'h0);
    check_val("lw12_rd",    cur_rd, 32'h8000_ABFF);
    drive(1'b0, 1'b1, F3_H, 32'h13, 32'h0000_FFFF);
    #1;
    check_val("sh13_mis",   cur_mis, 32'h1);
    check_val("sh13_stall", cur_stall, 32'h0);
    @(posedge clock); @(negedge clock); #1;
    check_val("sh13_idle",  cur_stall, 32'h0);
    drive(1'b0, 1'b1, F3_BU, 32'h10, 32'h0);
    #1;
    check_val("sbu_mis",    cur_mis, 32'h1);
    drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    #1;
    check_val("f3_011_mis", cur_mis, 32'h1);
    drive(1'b0, 1'b0, 3'b011, 32'h10, 32'h0);
    #1;
    check_val("noreq_mis",  cur_mis, 32'h0);
    @(negedge clock);
    load("lw10_post_mis", F3_W, 32'h10, 32'h8000_ABFF, 2);

    // Read and write together behaves as a store; readData keeps the last load
    access("swboth", 1'b1, 1'b1, F3_W, 32'h20, 32'h0000_1234, 2);
    check_val("swboth_rd", cur_rd, 32'h8000_ABFF);

    // Reset while BUSY discards the pending store
    drive(1'b0, 1'b1, F3_W, 32'h20, 32'h0000_5555);
    @(posedge clock); @(negedge clock); #1;
    check_val("busy_stall", cur_stall, 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("rst_busy_stall", cur_stall, 32'h0);
    check_val("rst_busy_rd",    cur_rd, 32'h0);
    @(negedge clock);
    load("lw20", F3_W, 32'h20, 32'h0000_1234, 2);

    // Zero wait states: one stall cycle; address wraps at 256 words
    sel0 = 1'b1;
    #1;
    check_val("ws0_idle_stall", cur_stall, 32'h0);
    @(negedge clock);
    access("ws0_sw400", 1'b0, 1'b1, F3_W, 32'h400, 32'hCAFE_F00D, 1);
    load("ws0_lw000", F3_W, 32'h000, 32'hCAFE_F00D, 1);
    load("ws0_lh002", F3_H, 32'h002, 32'hFFFF_CAFE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Data-memory stage directly downstream of `datapath`. It consumes `aluout` as the address, `readData2` as the store data, and the controller's `memread`/`memwrite` plus the instruction's funct3. It returns `readDataDMem` to the datapath and drives a `stall` back to the core. Memory latency is modelled with a configurable wait-state counter, so the core must hold its request until the access completes.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words in the RAM; power of two.
- `WAIT_STATES`, default 1: extra busy cycles per access, 0..15.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `memread`  in  1: load request.
- `memwrite`  in  1: store request.
- `funct3`  in  3: access size and sign (instr[14:12]).
- `addr`  in  32: byte address (datapath `aluout`).
- `writeData`  in  32: store data (datapath `readData2`).
- `readData`  out  32: extended load result (to `readDataDMem`).
- `stall`  out  1: core must hold PC and request while this is 1.
- `misaligned`  out  1: current request is illegal; the access is dropped.

## Operation
- `req = memread | memwrite`. When both are 1, the access is a store and no read happens.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap.
- Loads, selected by funct3:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`. Little-endian.
- Stores, selected by funct3:
  - 000 SB: writes the low byte of `writeData` into lane `addr[1:0]`.
  - 001 SH: writes the low half of `writeData` into half `addr[1]`.
  - 010 SW: writes the full word.
  - Unselected bytes are untouched.
- `misaligned` (combinational) is 1 when `req` is 1 and any of the following holds:
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - funct3 is 011, 110 or 111;
  - store with funct3[2]=1.
- While `misaligned`=1: no RAM change, `readData` unchanged, `stall`=0, FSM stays IDLE.
- FSM states are IDLE, BUSY and DONE; `cnt` is a 4-bit counter.
  - IDLE, legal `req`: if `WAIT_STATES`=0, go to DONE; else load `cnt`=`WAIT_STATES`-1 and go to BUSY.
  - BUSY: decrement `cnt`; when `cnt`=0, go to DONE.
  - DONE: always return to IDLE, whatever `req` is. The next request is taken in the following IDLE cycle.
- Commit: on the edge that enters DONE, the store is written or `readData` is loaded. Request inputs are sampled at that edge.
- `stall` = (IDLE & legal `req`) | BUSY. It is 0 in DONE.
- `readData` holds its value until the next load commits.

## Timing
- Reset values:
  - FSM = IDLE, `cnt`=0, `readData`=0.
  - `stall`=0 and `misaligned`=0, given inputs are low.
  - RAM contents are not reset.
- Access latency is `WAIT_STATES`+2 cycles from request to the core advancing:
  - `stall` is high for `WAIT_STATES`+1 cycles;
  - the core advances on the edge that leaves DONE.
- Back-to-back accesses are separated by one IDLE cycle, which asserts `stall` again.
- Reset asserted in BUSY: FSM goes to IDLE at that edge, the pending store is discarded and memory is unchanged.
- Reset asserted in the DONE-entry cycle: reset wins and no commit happens.
- Inputs changing while BUSY are not allowed. Only the values present at the DONE-entry edge are used.

## Structure
- `dmem_pkg` holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encodings: ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module `dmem_ram`: single-port `DEPTH_WORDS`×32 RAM, synchronous write with 4-bit byte-enable, combinational read.
- `dmem_unit` contains the FSM, the counter, lane select/extension and byte-enable generation.

## Test plan
- Reset, then SW 0x8000_00FF to addr 0x10, then LW from 0x10 → `readData`=0x8000_00FF; `stall` high for exactly 2 cycles (WAIT_STATES=1).
- LB from 0x10 → 0xFFFF_FFFF; LBU from 0x13 → 0x0000_0080; LH from 0x12 → 0xFFFF_8000; LHU from 0x10 → 0x0000_00FF.
- SB 0xAB to 0x11, then LW from 0x10 → 0x8000_ABFF, with the other bytes preserved.
- LW from 0x12 and SH to 0x13 → `misaligned`=1, `stall`=0, RAM and `readData` unchanged.
- `memread`=`memwrite`=1 with SW 0x1234 to 0x20 → word written, `readData` unchanged. Then assert `reset` mid-BUSY on SW 0x5555 to 0x20 → LW 0x20 still returns 0x1234.
- WAIT_STATES=0: LW → `stall` high for 1 cycle. Address 0x400 with DEPTH_WORDS=256 aliases to 0x000.
